am2940_dma_sequencer: RTL and testbench

//   Initiator side of the Am2940 DMA address generator. Takes a transfer request (mode, start address, word count).

---
 rtl/am2940_pkg.sv | 23 ++
 rtl/dma_beat_counter.sv | 40 ++++
 rtl/am2940_dma_sequencer.sv | 174 +++++++++++++++++
 tb/tb_am2940_dma_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/am2940_pkg.sv
// Shared definitions for the Am2940 DMA sequencer: 2940 instruction codes and
// the sequencer state encoding.
package am2940_pkg;

  localparam logic [2:0] I_WRCR   = 3'b000;
  localparam logic [2:0] I_RDCR   = 3'b001;
  localparam logic [2:0] I_RDWC   = 3'b010;
  localparam logic [2:0] I_RDAC   = 3'b011;
  localparam logic [2:0] I_REINIT = 3'b100;
  localparam logic [2:0] I_LDAC   = 3'b101;
  localparam logic [2:0] I_LDWC   = 3'b110;
  localparam logic [2:0] I_ENCT   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_CR = 3'd1,
    S_LD_AC = 3'd2,
    S_LD_WC = 3'd3,
    S_XFER  = 3'd4,
    S_DONE  = 3'd5
  } dma_state_t;

endpackage

// File: rtl/dma_beat_counter.sv
// Counts accepted memory beats of one transfer; last_o flags the beat that
// completes a transfer of limit_i beats.
module dma_beat_counter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [AW-1:0] limit_i,
  output logic          last_o
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + AW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == (limit_i - AW'(1)));

endmodule

// File: rtl/am2940_dma_sequencer.sv
// Initiator for an Am2940 address generator: programs CR/AC/WC through the
// instruction/data port, then steps both 2940 counters once per acked beat.
module am2940_dma_sequencer
  import am2940_pkg::*;
#(
  parameter int AW = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] word_count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    instr,
  output logic [AW-1:0] data_to_2940,
  output logic          aci,
  output logic          wci,
  input  logic          wco,
  output logic          mem_req,
  input  logic          mem_ack
);

  dma_state_t    state_q, state_d;
  logic [CW-1:0] mode_q, mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wc_q, wc_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_req_q, mem_req_d;
  logic [2:0]    instr_q, instr_d;
  logic [AW-1:0] data_q, data_d;
  logic          accept_s;
  logic          beat_s;
  logic          last_s;

  assign accept_s = (state_q == S_IDLE) && start;
  assign beat_s   = (state_q == S_XFER) && mem_ack;

  dma_beat_counter #(
    .AW(AW)
  ) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept_s),
    .inc_i   (beat_s),
    .limit_i (wc_q),
    .last_o  (last_s)
  );

  // Request latch, loaded only when a start is accepted
  always_comb begin
    mode_d = mode_q;
    addr_d = addr_q;
    wc_d   = wc_q;
    if (accept_s) begin
      mode_d = mode;
      addr_d = src_addr;
      wc_d   = word_count;
    end else begin
      mode_d = mode_q;
      addr_d = addr_q;
      wc_d   = wc_q;
    end
  end

  // Sticky error: early terminal count from the 2940 while beats remain
  always_comb begin
    err_d = err_q;
    if (accept_s) begin
      err_d = 1'b0;
    end else if ((state_q == S_XFER) && wco && !last_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LD_CR;
        else       state_d = S_IDLE;
      end
      S_LD_CR: state_d = S_LD_AC;
      S_LD_AC: state_d = S_LD_WC;
      S_LD_WC: begin
        if (wc_q == '0) state_d = S_DONE;
        else            state_d = S_XFER;
      end
      S_XFER: begin
        if (mem_ack && last_s) state_d = S_DONE;
        else                   state_d = S_XFER;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the upcoming state so they leave on flops
  always_comb begin
    instr_d   = I_RDCR;
    data_d    = '0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    mem_req_d = 1'b0;
    case (state_d)
      S_IDLE:  busy_d = 1'b0;
      S_LD_CR: begin
        instr_d = I_WRCR;
        data_d  = AW'(mode_d);
      end
      S_LD_AC: begin
        instr_d = I_LDAC;
        data_d  = addr_d;
      end
      S_LD_WC: begin
        instr_d = I_LDWC;
        data_d  = wc_d;
      end
      S_XFER: begin
        instr_d   = I_ENCT;
        mem_req_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // State, request latch and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      addr_q    <= '0;
      wc_q      <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_req_q <= 1'b0;
      instr_q   <= I_RDCR;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      wc_q      <= wc_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mem_req_q <= mem_req_d;
      instr_q   <= instr_d;
      data_q    <= data_d;
    end
  end

  // Carry-ins are combinational on the ack so each accepted beat steps the 2940 once
  assign aci = ~beat_s;
  assign wci = ~beat_s;

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign mem_req      = mem_req_q;
  assign instr        = instr_q;
  assign data_to_2940 = data_q;

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Bench for am2940_dma_sequencer: transaction-level reference model, a small
// behavioural Am2940 to close the wco loop, directed cases then random traffic.
module tb_am2940_dma_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, mem_ack, wco;
  logic [2:0] mode;
  logic [7:0] src_addr, word_count;
  logic       busy, done, err, aci, wci, mem_req;
  logic [2:0] instr;
  logic [7:0] data_to_2940;

  always #5 clk = ~clk;

  am2940_dma_sequencer #(.AW(8), .CW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src_addr(src_addr),
    .word_count(word_count), .busy(busy), .done(done), .err(err), .instr(instr),
    .data_to_2940(data_to_2940), .aci(aci), .wci(wci), .wco(wco),
    .mem_req(mem_req), .mem_ack(mem_ack)
  );

  typedef struct packed {logic [2:0] instr; logic [7:0] data;} op_t;

  // reference model of the sequencer, in transaction terms
  op_t        pre_q[$];
  bit         xfer_on = 1'b0, done_now = 1'b0, err_m = 1'b0, armed = 1'b0;
  int         beats_done = 0, m_wc = 0;
  logic [2:0] m_mode = 3'd0;
  logic [7:0] m_addr = 8'd0, m_wc8 = 8'd0;
  // behavioural 2940 registers
  logic [2:0] c_cr = 3'd0;
  logic [7:0] c_ac = 8'd0, c_wc = 8'd0;

  int vectors = 0, miscompares = 0, n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy_m();
    return (pre_q.size() != 0) || xfer_on || done_now;
  endfunction

  // one clock cycle: drive at negedge, compare, advance model and 2940, wait for next negedge
  task automatic cycle(input bit st, input bit ack, input bit r, input bit frc);
    logic [2:0] e_instr;
    logic [7:0] e_data, e_ac;
    bit e_busy, e_done, e_req, e_aci;
    op_t op;
    start = st; mem_ack = ack; rst = r; wco = (c_wc == 8'd1) | frc;
    #1;
    vectors++;
    e_instr = 3'b001; e_data = 8'd0; e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_aci = 1'b1;
    if (pre_q.size() != 0) begin
      e_instr = pre_q[0].instr; e_data = pre_q[0].data; e_busy = 1'b1;
    end else if (xfer_on) begin
      e_instr = 3'b111; e_busy = 1'b1; e_req = 1'b1; e_aci = ~ack;
    end else if (done_now) begin
      e_busy = 1'b1; e_done = 1'b1;
    end
    if (armed) begin
      chk("instr", instr, e_instr);
      chk("data", data_to_2940, e_data);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, err_m);
      chk("mem_req", mem_req, e_req);
      chk("aci", aci, e_aci);
      chk("wci", wci, e_aci);
      if (done_now) begin
        e_ac = m_mode[2] ? (m_addr - m_wc8) : (m_addr + m_wc8);
        chk("ac_end", c_ac, e_ac);
      end
    end
    // model step
    if (r) begin
      pre_q.delete(); xfer_on = 1'b0; done_now = 1'b0; err_m = 1'b0; armed = 1'b1;
    end else if (pre_q.size() != 0) begin
      void'(pre_q.pop_front());
      if (pre_q.size() == 0) begin
        if (m_wc == 0) done_now = 1'b1;
        else           xfer_on = 1'b1;
      end
    end else if (xfer_on) begin
      if (wco && (beats_done < m_wc - 1)) err_m = 1'b1;
      if (ack) begin
        beats_done++;
        if (beats_done == m_wc) begin xfer_on = 1'b0; done_now = 1'b1; end
      end
    end else if (done_now) begin
      done_now = 1'b0;
    end else if (st) begin
      m_mode = mode; m_addr = src_addr; m_wc8 = word_count; m_wc = int'(word_count);
      err_m = 1'b0; beats_done = 0;
      op.instr = 3'b000; op.data = {5'b00000, mode}; pre_q.push_back(op);
      op.instr = 3'b101; op.data = src_addr;         pre_q.push_back(op);
      op.instr = 3'b110; op.data = word_count;       pre_q.push_back(op);
    end
    // 2940 reacts to what the sequencer drives this cycle
    case (instr)
      3'b000: c_cr = data_to_2940[2:0];
      3'b101: c_ac = data_to_2940;
      3'b110: c_wc = data_to_2940;
      3'b111: begin
        if (!aci) c_ac = c_cr[2] ? (c_ac - 8'd1) : (c_ac + 8'd1);
        if (!wci) c_wc = c_wc - 8'd1;
      end
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  // directed transfer; ack_kind 0 = always acked, 1 = acked on alternate XFER cycles
  task automatic xfer(input logic [2:0] md, input logic [7:0] ad, input logic [7:0] wc,
                      input int ack_kind, input bit frc_first, input int rst_beat,
                      input int exp_done, input logic [7:0] exp_ac, input bit exp_err);
    int k = 0, xc = 0;
    bit was_done, ack, r, frc;
    mode = md; src_addr = ad; word_count = wc;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 600 && busy_m(); i++) begin
      k++;
      was_done = done_now;
      ack = (ack_kind == 1 && xfer_on) ? (xc % 2 == 0) : 1'b1;
      frc = frc_first && xfer_on && (xc == 0);
      r = (rst_beat >= 0) && xfer_on && (beats_done == rst_beat);
      if (xfer_on) xc++;
      cycle(1'b0, ack, r, frc);
      if (was_done && exp_done >= 0) begin
        chk("done_cycle", k, exp_done);
        chk("ac_at_done", c_ac, exp_ac);
      end
    end
    if (busy_m()) begin
      miscompares++;
      $display("FAIL timeout: transfer still busy after 600 cycles");
    end
    if (rst_beat >= 0) begin
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_aci", aci, 1'b1);
      chk("rst_wci", wci, 1'b1);
    end
    chk("err_after", err, exp_err);
  endtask

  initial begin
    int sel;
    rst = 1'b1; start = 1'b0; mode = 3'd0; src_addr = 8'd0; word_count = 8'd0;
    mem_ack = 1'b0; wco = 1'b0;
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_instr", instr, 3'b001);
    chk("rst_data", data_to_2940, 8'd0);
    chk("rst_busy0", busy, 1'b0);
    chk("rst_aci0", aci, 1'b1);

    xfer(3'b010, 8'h02, 8'h03, 0, 1'b0, -1, 7, 8'h05, 1'b0);
    xfer(3'b010, 8'h02, 8'h03, 1, 1'b0, -1, 9, 8'h05, 1'b0);
    xfer(3'b010, 8'h33, 8'h00, 0, 1'b0, -1, 4, 8'h33, 1'b0);
    xfer(3'b100, 8'h10, 8'h04, 0, 1'b0, -1, 8, 8'h0C, 1'b0);
    xfer(3'b010, 8'h02, 8'h03, 0, 1'b1, -1, 7, 8'h05, 1'b1);
    xfer(3'b010, 8'h02, 8'h03, 0, 1'b0, -1, 7, 8'h05, 1'b0);
    xfer(3'b010, 8'h02, 8'h05, 0, 1'b0, 1, -1, 8'h00, 1'b0);
    xfer(3'b010, 8'h40, 8'h02, 0, 1'b0, -1, 6, 8'h42, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      mode = 3'($urandom);
      src_addr = 8'($urandom);
      sel = $urandom_range(0, 49);
      word_count = (sel == 0) ? 8'd255 : (sel < 6) ? 8'd0 : 8'($urandom_range(1, 6));
      cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
